// File: rtl/ssp_rx_fifo_if.sv
// Bus between the SSP receive shifter / APB read port and the receive FIFO.
// The SSPRXOVR flag is present only when SSP_RX_OVERRUN_EN is defined.
interface ssp_rx_fifo_if #(
  parameter int DATA_W = 8
);
  logic              PSEL;
  logic              PWRITE;
  logic [DATA_W-1:0] RxData;
  logic              write_fifo;
  logic [DATA_W-1:0] PRDATA;
  logic              rx_fifo_full;
  logic              rx_fifo_empty;
  logic              SSPRXINTR;
`ifdef SSP_RX_OVERRUN_EN
  logic              SSPRXOVR;

  modport master (
    output PSEL, PWRITE, RxData, write_fifo,
    input  PRDATA, rx_fifo_full, rx_fifo_empty, SSPRXINTR, SSPRXOVR
  );

  modport slave (
    input  PSEL, PWRITE, RxData, write_fifo,
    output PRDATA, rx_fifo_full, rx_fifo_empty, SSPRXINTR, SSPRXOVR
  );
`else
  modport master (
    output PSEL, PWRITE, RxData, write_fifo,
    input  PRDATA, rx_fifo_full, rx_fifo_empty, SSPRXINTR
  );

  modport slave (
    input  PSEL, PWRITE, RxData, write_fifo,
    output PRDATA, rx_fifo_full, rx_fifo_empty, SSPRXINTR
  );
`endif
endinterface

// File: rtl/ssp_rx_fifo.sv
// SSP receive FIFO: buffers frames from the receive shifter (one entry per
// rising edge of write_fifo) and returns them on APB reads via PRDATA.
// A frame arriving while full waits in a one-entry hold register and is
// pushed in the first cycle a pop frees a slot.
// Optional feature macro: SSP_RX_OVERRUN_EN -- when defined, a second frame
// arriving while one is already held is dropped and the sticky SSPRXOVR flag
// is raised; when undefined, the newest frame replaces the held one.
module ssp_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input logic          PCLK,
  input logic          CLEAR,
  ssp_rx_fifo_if.slave bus
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              pend_q, pend_d;
  logic              wr_dly_q, wr_dly_d;
`ifdef SSP_RX_OVERRUN_EN
  logic              ovr_q, ovr_d;
`endif

  logic              full, empty;
  logic              wr_rise, rd_req, pop, push;
  logic [DATA_W-1:0] push_data;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Next-state logic: edge detect, capture/hold, push/pop, pointers and count.
  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    prdata_d = prdata_q;
    hold_d   = hold_q;
    pend_d   = pend_q;
    wr_dly_d = bus.write_fifo;
`ifdef SSP_RX_OVERRUN_EN
    ovr_d    = ovr_q;
`endif

    wr_rise = bus.write_fifo & ~wr_dly_q;
    rd_req  = bus.PSEL & ~bus.PWRITE;
    pop     = rd_req & ~empty;
    // A slot is available if not full, or if this cycle's pop frees one.
    push    = (pend_q | wr_rise) & (~full | pop);

`ifdef SSP_RX_OVERRUN_EN
    // Older held frame has priority; a new frame during pend is dropped.
    push_data = pend_q ? hold_q : bus.RxData;
`else
    // Newest frame wins; RxData bypasses hold in its capture cycle.
    push_data = wr_rise ? bus.RxData : hold_q;
`endif

    if (push) begin
      wptr_d = wptr_q + 1'b1;
      pend_d = 1'b0;
    end else if (wr_rise) begin
      hold_d = push_data;
      pend_d = 1'b1;
    end

    if (pop) begin
      rptr_d   = rptr_q + 1'b1;
      prdata_d = mem_q[rptr_q];
    end else if (rd_req) begin
      prdata_d = '0;
    end

    count_d = count_q + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};

`ifdef SSP_RX_OVERRUN_EN
    if (wr_rise && pend_q) begin
      ovr_d = 1'b1;
    end else if (pop) begin
      ovr_d = 1'b0;
    end
`endif
  end

  // Control and output registers; CLEAR discards any held frame.
  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      prdata_q <= '0;
      hold_q   <= '0;
      pend_q   <= 1'b0;
      wr_dly_q <= 1'b0;
`ifdef SSP_RX_OVERRUN_EN
      ovr_q    <= 1'b0;
`endif
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      prdata_q <= prdata_d;
      hold_q   <= hold_d;
      pend_q   <= pend_d;
      wr_dly_q <= wr_dly_d;
`ifdef SSP_RX_OVERRUN_EN
      ovr_q    <= ovr_d;
`endif
    end
  end

  // Storage array: written on push, never reset (pointers define validity).
  always_ff @(posedge PCLK) begin
    if (!CLEAR && push) begin
      mem_q[wptr_q] <= push_data;
    end
  end

  assign bus.PRDATA        = prdata_q;
  assign bus.rx_fifo_full  = full;
  assign bus.rx_fifo_empty = empty;
  assign bus.SSPRXINTR     = full;
`ifdef SSP_RX_OVERRUN_EN
  assign bus.SSPRXOVR      = ovr_q;
`endif

endmodule

// File: tb/tb_ssp_rx_fifo.sv
// Bench for ssp_rx_fifo: scoreboard queue of expected PRDATA values, filled
// as frames are driven and drained as reads return data.
module tb_ssp_rx_fifo;

  logic clk = 1'b0;
  logic clear;

  ssp_rx_fifo_if #(.DATA_W(8)) bif ();

  ssp_rx_fifo #(.DATA_W(8), .DEPTH(4), .ADDR_W(2)) dut (
    .PCLK  (clk),
    .CLEAR (clear),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] sbq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: write_fifo high for one cycle, then low so the next rise is seen.
  task automatic send(input logic [7:0] d, input bit expect_q);
    bif.write_fifo = 1'b1;
    bif.RxData     = d;
    if (expect_q) sbq.push_back(d);
    tick();
    bif.write_fifo = 1'b0;
    tick();
  endtask

  task automatic pop_one(input string tag);
    logic [7:0] exp;
    exp = (sbq.size() > 0) ? sbq.pop_front() : 8'h00;
    bif.PSEL   = 1'b1;
    bif.PWRITE = 1'b0;
    tick();
    bif.PSEL   = 1'b0;
    chk(tag, bif.PRDATA, exp);
  endtask

  initial begin
    clear          = 1'b1;
    bif.PSEL       = 1'b0;
    bif.PWRITE     = 1'b0;
    bif.RxData     = 8'h00;
    bif.write_fifo = 1'b0;
    tick();
    tick();
    chk("rst_empty", bif.rx_fifo_empty, 1);
    chk("rst_full",  bif.rx_fifo_full,  0);
    chk("rst_prdata", bif.PRDATA, 8'h00);
    chk("rst_intr",  bif.SSPRXINTR, 0);
`ifdef SSP_RX_OVERRUN_EN
    chk("rst_ovr",   bif.SSPRXOVR, 0);
`endif
    clear = 1'b0;
    tick();

    // Single frame held high for 6 cycles -> exactly one entry, visible after 1.
    bif.write_fifo = 1'b1;
    bif.RxData     = 8'hA5;
    sbq.push_back(8'hA5);
    tick();
    chk("single_notempty_1cyc", bif.rx_fifo_empty, 0);
    repeat (5) tick();
    bif.write_fifo = 1'b0;
    tick();
    chk("single_notfull", bif.rx_fifo_full, 0);
    // APB write cycle: must not pop
    bif.PSEL   = 1'b1;
    bif.PWRITE = 1'b1;
    tick();
    bif.PSEL   = 1'b0;
    bif.PWRITE = 1'b0;
    chk("pwrite_prdata", bif.PRDATA, 8'h00);
    chk("pwrite_notempty", bif.rx_fifo_empty, 0);
    pop_one("single_pop");
    chk("single_empty_after", bif.rx_fifo_empty, 1);

    // Fill and wrap.
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
    chk("fill_full", bif.rx_fifo_full, 1);
    chk("fill_intr", bif.SSPRXINTR, 1);
    pop_one("wrap_pop0");
    pop_one("wrap_pop1");
    chk("wrap_notfull", bif.rx_fifo_full, 0);
    send(8'h05, 1'b1);
    send(8'h06, 1'b1);
    chk("wrap_full_again", bif.rx_fifo_full, 1);
    for (int i = 0; i < 4; i++) pop_one("wrap_drain");
    chk("wrap_empty", bif.rx_fifo_empty, 1);

    // Empty read returns zero and leaves pointers alone.
    pop_one("empty_read");
    chk("empty_read_empty", bif.rx_fifo_empty, 1);
    send(8'h33, 1'b1);
    pop_one("after_empty_read");

    // Full stall: frame waits in hold until a pop frees a slot.
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b1);
    send(8'h77, 1'b1);
    chk("stall_full", bif.rx_fifo_full, 1);
    pop_one("stall_pop");
    chk("stall_still_full", bif.rx_fifo_full, 1);
    for (int i = 0; i < 4; i++) pop_one("stall_drain");
    chk("stall_empty", bif.rx_fifo_empty, 1);

    // Simultaneous push and pop while full.
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), 1'b1);
    begin
      logic [7:0] exp;
      exp = sbq.pop_front();
      sbq.push_back(8'h24);
      bif.write_fifo = 1'b1;
      bif.RxData     = 8'h24;
      bif.PSEL       = 1'b1;
      bif.PWRITE     = 1'b0;
      tick();
      bif.PSEL       = 1'b0;
      bif.write_fifo = 1'b0;
      chk("simul_prdata", bif.PRDATA, exp);
      chk("simul_full", bif.rx_fifo_full, 1);
      tick();
    end
    for (int i = 0; i < 4; i++) pop_one("simul_drain");
    chk("simul_empty", bif.rx_fifo_empty, 1);

    // Overrun: second frame arrives while one is already held.
    for (int i = 0; i < 4; i++) send(8'h30 + 8'(i), 1'b1);
`ifdef SSP_RX_OVERRUN_EN
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    chk("ovr_set", bif.SSPRXOVR, 1);
    pop_one("ovr_pop");
    chk("ovr_cleared", bif.SSPRXOVR, 0);
`else
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    pop_one("ovr_pop");
`endif
    chk("ovr_full", bif.rx_fifo_full, 1);
    for (int i = 0; i < 4; i++) pop_one("ovr_drain");
    chk("ovr_empty", bif.rx_fifo_empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
